// File: rtl/alu_pkg.sv
// Shared ALU definitions: scheduler state encoding, slice width and requester-id width.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int NIBBLE = 4;
  localparam int ID_W   = 1;

endpackage

// File: rtl/add_sub_sched_if.sv
// Requester and result channels of the shared add/sub scheduler.
interface add_sub_sched_if #(
  parameter int WIDTH = 16
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req0_m;
  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             req1_m;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_s;
  logic             res_c;
  logic             res_v;
  logic             res_id;

  modport master (
    output req0_valid, req0_a, req0_b, req0_m,
    output req1_valid, req1_a, req1_b, req1_m,
    output res_ready,
    input  req0_ready, req1_ready,
    input  res_valid, res_s, res_c, res_v, res_id
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_m,
    input  req1_valid, req1_a, req1_b, req1_m,
    input  res_ready,
    output req0_ready, req1_ready,
    output res_valid, res_s, res_c, res_v, res_id
  );
endinterface

// File: rtl/nibble_add_sub.sv
// 4-bit ripple add/sub slice; b is inverted when m=1, c3 is the carry into bit 3.
module nibble_add_sub
  import alu_pkg::*;
(
  input  logic [NIBBLE-1:0] a,
  input  logic [NIBBLE-1:0] b,
  input  logic              m,
  input  logic              cin,
  output logic [NIBBLE-1:0] s,
  output logic              cout,
  output logic              c3
);
  logic [NIBBLE-1:0] bx;
  logic [3:0]        lo;
  logic [1:0]        hi;

  always_comb begin
    bx   = b ^ {NIBBLE{m}};
    lo   = {1'b0, a[2:0]} + {1'b0, bx[2:0]} + {3'b000, cin};
    hi   = {1'b0, a[3]} + {1'b0, bx[3]} + {1'b0, lo[3]};
    c3   = lo[3];
    s    = {hi[0], lo[2:0]};
    cout = hi[1];
  end
endmodule

// File: rtl/add_sub_sched.sv
// Round-robin scheduler for two requesters sharing one nibble-serial add/sub slice;
// operands run LSB nibble first through a registered carry, result held until consumed.
module add_sub_sched
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  add_sub_sched_if.slave  bus,
  output logic            busy
);
  localparam int N     = WIDTH / NIBBLE;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              carry_q, carry_d;
  logic [ID_W-1:0]   last_grant_q, last_grant_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, s_q, s_d;
  logic              m_q, m_d, v_q, v_d;
  logic [ID_W-1:0]   id_q, id_d;

  logic [ID_W-1:0]   grant;
  logic              accept;
  logic [NIBBLE-1:0] nib_a, nib_b, nib_s;
  logic              nib_cout, nib_c3;

  // Tie goes to whoever did not win last time.
  always_comb begin
    grant = '0;
    if (bus.req0_valid && bus.req1_valid) grant = ~last_grant_q;
    else if (bus.req1_valid)              grant = ID_W'(1);
  end

  assign bus.req0_ready = (state_q == IDLE) && bus.req0_valid && (grant == ID_W'(0));
  assign bus.req1_ready = (state_q == IDLE) && bus.req1_valid && (grant == ID_W'(1));
  assign accept         = bus.req0_ready || bus.req1_ready;

  assign nib_a = a_q[idx_q*NIBBLE +: NIBBLE];
  assign nib_b = b_q[idx_q*NIBBLE +: NIBBLE];

  nibble_add_sub u_slice (
    .a    (nib_a),
    .b    (nib_b),
    .m    (m_q),
    .cin  (carry_q),
    .s    (nib_s),
    .cout (nib_cout),
    .c3   (nib_c3)
  );

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    carry_d      = carry_q;
    last_grant_d = last_grant_q;
    a_d          = a_q;
    b_d          = b_q;
    m_d          = m_q;
    id_d         = id_q;
    s_d          = s_q;
    v_d          = v_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          a_d          = (grant == ID_W'(1)) ? bus.req1_a : bus.req0_a;
          b_d          = (grant == ID_W'(1)) ? bus.req1_b : bus.req0_b;
          m_d          = (grant == ID_W'(1)) ? bus.req1_m : bus.req0_m;
          carry_d      = (grant == ID_W'(1)) ? bus.req1_m : bus.req0_m;
          id_d         = grant;
          idx_d        = '0;
          last_grant_d = grant;
          state_d      = CALC;
        end
      end
      CALC: begin
        s_d[idx_q*NIBBLE +: NIBBLE] = nib_s;
        carry_d = nib_cout;
        idx_d   = idx_q + 1'b1;
        if (idx_q == IDX_LAST) begin
          v_d     = nib_c3 ^ nib_cout;
          idx_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      carry_q      <= 1'b0;
      last_grant_q <= ID_W'(1);
      a_q          <= '0;
      b_q          <= '0;
      m_q          <= 1'b0;
      id_q         <= '0;
      s_q          <= '0;
      v_q          <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      carry_q      <= carry_d;
      last_grant_q <= last_grant_d;
      a_q          <= a_d;
      b_q          <= b_d;
      m_q          <= m_d;
      id_q         <= id_d;
      s_q          <= s_d;
      v_q          <= v_d;
    end
  end

  assign bus.res_valid = (state_q == DONE);
  assign bus.res_s     = s_q;
  assign bus.res_c     = carry_q;
  assign bus.res_v     = v_q;
  assign bus.res_id    = id_q;
  assign busy          = (state_q != IDLE);
endmodule

// File: tb/tb_add_sub_sched.sv
// Bench for add_sub_sched: directed corner cases, arbitration, backpressure and reset abort,
// then randomized traffic, all checked against a transaction-level model every cycle.
module tb_add_sub_sched;
  localparam int WIDTH = 16;
  localparam int N     = WIDTH / 4;

  logic clk = 1'b0;
  logic rst_n;
  logic busy;

  always #5 clk = ~clk;

  add_sub_sched_if #(.WIDTH(WIDTH)) bus ();

  add_sub_sched #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic             p_vld [2];
  logic [WIDTH-1:0] p_a   [2];
  logic [WIDTH-1:0] p_b   [2];
  logic             p_m   [2];
  logic             rdy_drv;

  bit               in_flight;
  int               acc_cyc;
  logic             last_w;
  logic [WIDTH-1:0] exp_s;
  logic             exp_c, exp_v, exp_id;
  logic [WIDTH-1:0] lr_s;
  logic             lr_c, lr_v, lr_id;
  int               n_done;
  int               id_log[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Result of one operation straight from the arithmetic definition.
  task automatic model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic m,
                       input logic id);
    logic [WIDTH:0] wide;
    if (m) begin
      exp_s = a - b;
      exp_c = (a >= b);
      exp_v = (a[WIDTH-1] != b[WIDTH-1]) && (exp_s[WIDTH-1] != a[WIDTH-1]);
    end else begin
      wide  = {1'b0, a} + {1'b0, b};
      exp_s = wide[WIDTH-1:0];
      exp_c = wide[WIDTH];
      exp_v = (a[WIDTH-1] == b[WIDTH-1]) && (exp_s[WIDTH-1] != a[WIDTH-1]);
    end
    exp_id = id;
  endtask

  task automatic drive();
    bus.req0_valid = p_vld[0];
    bus.req0_a     = p_a[0];
    bus.req0_b     = p_b[0];
    bus.req0_m     = p_m[0];
    bus.req1_valid = p_vld[1];
    bus.req1_a     = p_a[1];
    bus.req1_b     = p_b[1];
    bus.req1_m     = p_m[1];
    bus.res_ready  = rdy_drv;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_res_valid"}, 32'(bus.res_valid), 32'd0);
    chk({tag, "_busy"},      32'(busy),          32'd0);
    chk({tag, "_res_s"},     32'(bus.res_s),     32'd0);
    chk({tag, "_res_c"},     32'(bus.res_c),     32'd0);
    chk({tag, "_res_v"},     32'(bus.res_v),     32'd0);
    chk({tag, "_res_id"},    32'(bus.res_id),    32'd0);
    chk({tag, "_ready0"},    32'(bus.req0_ready), 32'd0);
    chk({tag, "_ready1"},    32'(bus.req1_ready), 32'd0);
  endtask

  // Per-cycle comparison against the model, sampled on the falling edge.
  task automatic observe();
    bit   was_busy, has, done_now;
    logic w;
    cyc++;
    if (!rst_n) begin
      check_reset_outputs("rst");
      return;
    end
    was_busy = in_flight;
    done_now = in_flight && (cyc - acc_cyc >= N + 1);
    chk("busy", 32'(busy), 32'(was_busy));
    chk("res_valid", 32'(bus.res_valid), 32'(done_now));
    if (done_now) begin
      chk("res_s",  32'(bus.res_s),  32'(exp_s));
      chk("res_c",  32'(bus.res_c),  32'(exp_c));
      chk("res_v",  32'(bus.res_v),  32'(exp_v));
      chk("res_id", 32'(bus.res_id), 32'(exp_id));
      if (bus.res_ready) begin
        lr_s  = bus.res_s;
        lr_c  = bus.res_c;
        lr_v  = bus.res_v;
        lr_id = bus.res_id;
        id_log.push_back(int'(bus.res_id));
        n_done++;
        in_flight = 0;
      end
    end
    has = 0;
    w   = 1'b0;
    if (!was_busy) begin
      if (p_vld[0] && p_vld[1]) begin has = 1; w = ~last_w; end
      else if (p_vld[0])        begin has = 1; w = 1'b0;    end
      else if (p_vld[1])        begin has = 1; w = 1'b1;    end
    end
    chk("req0_ready", 32'(bus.req0_ready), 32'(has && (w == 1'b0)));
    chk("req1_ready", 32'(bus.req1_ready), 32'(has && (w == 1'b1)));
    if (has) begin
      model(p_a[w], p_b[w], p_m[w], w);
      in_flight = 1;
      acc_cyc   = cyc;
      last_w    = w;
      p_vld[w]  = 1'b0;
    end
  endtask

  task automatic step();
    @(negedge clk);
    observe();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    p_vld[0] = 1'b0;
    p_vld[1] = 1'b0;
    drive();
    in_flight = 0;
    last_w    = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 200; i++) begin
      if (!in_flight && !p_vld[0] && !p_vld[1]) return;
      step();
    end
    total++;
    bad++;
    $display("FAIL %s_timeout: got busy expected idle within 200 cycles", tag);
  endtask

  task automatic post(input int id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic m);
    p_vld[id] = 1'b1;
    p_a[id]   = a;
    p_b[id]   = b;
    p_m[id]   = m;
  endtask

  task automatic run_op(input int id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic m, input string tag);
    post(id, a, b, m);
    drive();
    wait_idle(tag);
  endtask

  function automatic logic [WIDTH-1:0] rand_opnd();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return '1;
      2: return {1'b0, {(WIDTH-1){1'b1}}};
      3: return {1'b1, {(WIDTH-1){1'b0}}};
      default: return WIDTH'($urandom());
    endcase
  endfunction

  initial begin
    int cnt;
    int start_done;
    p_vld[0] = 1'b0; p_vld[1] = 1'b0;
    p_a[0] = '0; p_a[1] = '0; p_b[0] = '0; p_b[1] = '0; p_m[0] = 1'b0; p_m[1] = 1'b0;
    rdy_drv  = 1'b1;
    rst_n    = 1'b1;
    in_flight = 0;
    acc_cyc   = 0;
    last_w    = 1'b1;
    n_done    = 0;
    drive();
    #2;
    do_reset();

    run_op(0, 16'h1234, 16'h0FFF, 1'b0, "add");
    chk("lit_add_s", 32'(lr_s), 32'h2233);
    chk("lit_add_c", 32'(lr_c), 32'd0);
    chk("lit_add_v", 32'(lr_v), 32'd0);
    chk("lit_add_id", 32'(lr_id), 32'd0);

    run_op(1, 16'h0005, 16'h0007, 1'b1, "sub_neg");
    chk("lit_sub_s", 32'(lr_s), 32'hFFFE);
    chk("lit_sub_c", 32'(lr_c), 32'd0);
    chk("lit_sub_v", 32'(lr_v), 32'd0);
    chk("lit_sub_id", 32'(lr_id), 32'd1);
    run_op(1, 16'h0007, 16'h0005, 1'b1, "sub_pos");
    chk("lit_sub2_s", 32'(lr_s), 32'h0002);
    chk("lit_sub2_c", 32'(lr_c), 32'd1);

    run_op(0, 16'h7FFF, 16'h0001, 1'b0, "ovf");
    chk("lit_ovf_s", 32'(lr_s), 32'h8000);
    chk("lit_ovf_v", 32'(lr_v), 32'd1);
    chk("lit_ovf_c", 32'(lr_c), 32'd0);
    run_op(0, 16'hFFFF, 16'h0001, 1'b0, "wrap");
    chk("lit_wrap_s", 32'(lr_s), 32'h0000);
    chk("lit_wrap_c", 32'(lr_c), 32'd1);
    chk("lit_wrap_v", 32'(lr_v), 32'd0);

    // Both requesters saturated: grants must alternate starting with 0.
    do_reset();
    id_log.delete();
    start_done = n_done;
    for (int i = 0; i < 200 && (n_done - start_done) < 4; i++) begin
      for (int x = 0; x < 2; x++)
        if (!p_vld[x]) post(x, rand_opnd(), rand_opnd(), 1'($urandom_range(0, 1)));
      drive();
      step();
    end
    p_vld[0] = 1'b0;
    p_vld[1] = 1'b0;
    drive();
    wait_idle("arb");
    chk("arb_count", 32'(id_log.size() >= 4), 32'd1);
    if (id_log.size() >= 4) begin
      chk("arb_id0", 32'(id_log[0]), 32'd0);
      chk("arb_id1", 32'(id_log[1]), 32'd1);
      chk("arb_id2", 32'(id_log[2]), 32'd0);
      chk("arb_id3", 32'(id_log[3]), 32'd1);
    end

    // Held result under backpressure, with a competing request waiting.
    rdy_drv = 1'b0;
    post(0, 16'hA5A5, 16'h1111, 1'b1);
    drive();
    cnt = 0;
    for (int i = 0; i < N + 6; i++) begin
      step();
      if (i == N + 1) post(1, 16'h0100, 16'h0200, 1'b0);
      drive();
      if (bus.res_valid) cnt++;
    end
    chk("bp_done_cycles", 32'(cnt), 32'd6);
    rdy_drv = 1'b1;
    drive();
    wait_idle("bp");
    chk("bp_last_s", 32'(lr_s), 32'h0300);
    chk("bp_last_id", 32'(lr_id), 32'd1);

    // Abort with idx=2 in flight; nothing may come out afterwards.
    post(0, 16'h4321, 16'h1234, 1'b0);
    drive();
    step();
    step();
    step();
    cnt = n_done;
    do_reset();
    for (int i = 0; i < 10; i++) step();
    chk("abort_no_result", 32'(n_done), 32'(cnt));
    run_op(0, 16'h4321, 16'h1234, 1'b0, "after_abort");
    chk("abort_retry_s", 32'(lr_s), 32'h5555);

    // Randomized traffic with random consumer stalls.
    for (int i = 0; i < 1500; i++) begin
      for (int x = 0; x < 2; x++)
        if (!p_vld[x] && $urandom_range(0, 3) == 0)
          post(x, rand_opnd(), rand_opnd(), 1'($urandom_range(0, 1)));
      rdy_drv = ($urandom_range(0, 3) != 0);
      drive();
      step();
    end
    rdy_drv = 1'b1;
    drive();
    wait_idle("random");
    chk("random_progress", 32'(n_done > 100), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
